// File: rtl/scoreboard.sv
// Scoreboard: in-order issue, out-of-order writeback, in-order commit of decoded entries.
// Optional feature: define SCOREBOARD_FWD_EN to forward completed results to operand reads.
package scoreboard_pkg;
   localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  trans_id;
      logic [3:0]  fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;
      exception    ex;
   } scoreboard_entry;
endpackage

module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   output logic            full_o,
   input  scoreboard_entry decoded_instr_i,
   input  logic            decoded_instr_valid_i,
   output logic            decoded_instr_ack_o,
   output scoreboard_entry issue_instr_o,
   output logic            issue_instr_valid_o,
   input  logic            issue_ack_i,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   output logic [63:0]     rs1_o,
   output logic [63:0]     rs2_o,
   output logic            rs1_valid_o,
   output logic            rs2_valid_o,
   input  logic [4:0]      trans_id_i,
   input  logic [63:0]     wdata_i,
   input  logic            wb_valid_i,
   input  exception        ex_i,
   output scoreboard_entry commit_instr_o,
   output logic            commit_valid_o,
   input  logic            commit_ack_i
);
   localparam int unsigned PW = $clog2(NR_ENTRIES);
   localparam int unsigned CW = PW + 1;

   scoreboard_entry       mem [NR_ENTRIES];
   scoreboard_entry       ins_entry;
   logic [NR_ENTRIES-1:0] occupied;
   logic [NR_ENTRIES-1:0] issued;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         iss_ptr;
   logic [PW-1:0]         cmt_ptr;
   logic [CW-1:0]         count;
   logic [PW-1:0]         wb_idx;
   logic                  clear;
   logic                  do_ins;
   logic                  do_iss;
   logic                  do_cmt;
   logic                  do_wb;

   assign clear  = rst_i || flush_i;
   assign full_o = (count == CW'(NR_ENTRIES));
   assign decoded_instr_ack_o = !full_o;

   // A per-slot issued bit keeps "full and fully issued" distinct from "full and nothing issued".
   assign issue_instr_o       = mem[iss_ptr];
   assign issue_instr_valid_o = occupied[iss_ptr] && !issued[iss_ptr];
   assign commit_instr_o      = mem[cmt_ptr];
   assign commit_valid_o      = occupied[cmt_ptr] && issued[cmt_ptr] && mem[cmt_ptr].valid;

   assign do_ins = decoded_instr_valid_i && !full_o;
   assign do_iss = issue_ack_i && issue_instr_valid_o;
   assign do_cmt = commit_ack_i && commit_valid_o;
   assign wb_idx = trans_id_i[PW-1:0];
   assign do_wb  = wb_valid_i && ({1'b0, trans_id_i} < 6'(NR_ENTRIES)) && occupied[wb_idx];

   always_comb begin
      // NOTE: every field gets a value before any override, so this block cannot infer a latch.
      ins_entry          = decoded_instr_i;
      ins_entry.trans_id = 5'(wr_ptr);
      ins_entry.valid    = decoded_instr_i.ex.valid;
   end

   // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         wr_ptr   <= '0;
         iss_ptr  <= '0;
         cmt_ptr  <= '0;
         count    <= '0;
         occupied <= '0;
         issued   <= '0;
      end else begin
         if (do_ins) begin
            wr_ptr           <= wr_ptr + PW'(1);
            occupied[wr_ptr] <= 1'b1;
            issued[wr_ptr]   <= 1'b0;
         end
         if (do_iss) begin
            iss_ptr         <= iss_ptr + PW'(1);
            issued[iss_ptr] <= 1'b1;
         end
         if (do_cmt) begin
            cmt_ptr           <= cmt_ptr + PW'(1);
            occupied[cmt_ptr] <= 1'b0;
         end
         case ({do_ins, do_cmt})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: payloads are deliberately not reset; the occupied bits alone mark live slots.
   always_ff @(posedge clk_i) begin
      if (!clear) begin
         if (do_ins) begin
            mem[wr_ptr] <= ins_entry;
         end
         if (do_wb) begin
            mem[wb_idx].result <= wdata_i;
            mem[wb_idx].valid  <= 1'b1;
            if (ex_i.valid) begin
               mem[wb_idx].ex <= ex_i;
            end
         end
      end
   end

`ifdef SCOREBOARD_FWD_EN
   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } fwd_t;

   fwd_t fwd1;
   fwd_t fwd2;

   // Walk from oldest to youngest so the last match wins.
   function automatic fwd_t lookup(input logic [4:0] rs);
      fwd_t          r;
      logic [PW-1:0] idx;
      r = '0;
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
         idx = cmt_ptr + PW'(i);
         if (occupied[idx] && issued[idx] && (mem[idx].rd == rs)) begin
            r.valid = mem[idx].valid;
            r.data  = mem[idx].result;
         end
      end
      if ((rs == 5'd0) || !r.valid) begin
         r = '0;
      end
      return r;
   endfunction

   always_comb begin
      fwd1 = lookup(rs1_i);
      fwd2 = lookup(rs2_i);
   end

   assign rs1_valid_o = fwd1.valid;
   assign rs1_o       = fwd1.data;
   assign rs2_valid_o = fwd2.valid;
   assign rs2_o       = fwd2.data;
`else
   logic unused_rs;
   assign unused_rs   = ^{rs1_i, rs2_i};
   assign rs1_valid_o = 1'b0;
   assign rs1_o       = '0;
   assign rs2_valid_o = 1'b0;
   assign rs2_o       = '0;
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: vector table for fill/drain and out-of-order writeback,
// hand sequences for wrap-around, flush, decode exception and operand forwarding.
module tb_scoreboard;
   import scoreboard_pkg::*;

`ifdef SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            full;
   scoreboard_entry dec_instr;
   logic            dec_valid;
   logic            dec_ack;
   scoreboard_entry issue_instr;
   logic            issue_valid;
   logic            issue_ack;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [63:0]     rs1_data;
   logic [63:0]     rs2_data;
   logic            rs1_valid;
   logic            rs2_valid;
   logic [4:0]      trans_id;
   logic [63:0]     wdata;
   logic            wb_valid;
   exception        ex_in;
   scoreboard_entry commit_instr;
   logic            commit_valid;
   logic            commit_ack;

   int n_checks = 0;
   int n_fail   = 0;

   scoreboard #(.NR_ENTRIES(8)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .full_o(full),
      .decoded_instr_i(dec_instr), .decoded_instr_valid_i(dec_valid), .decoded_instr_ack_o(dec_ack),
      .issue_instr_o(issue_instr), .issue_instr_valid_o(issue_valid), .issue_ack_i(issue_ack),
      .rs1_i(rs1), .rs2_i(rs2), .rs1_o(rs1_data), .rs2_o(rs2_data),
      .rs1_valid_o(rs1_valid), .rs2_valid_o(rs2_valid),
      .trans_id_i(trans_id), .wdata_i(wdata), .wb_valid_i(wb_valid), .ex_i(ex_in),
      .commit_instr_o(commit_instr), .commit_valid_o(commit_valid), .commit_ack_i(commit_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic        dv;
      logic [4:0]  rd;
      logic        ia;
      logic        wv;
      logic [4:0]  tid;
      logic [63:0] wd;
      logic        ca;
      logic        e_full;
      logic        e_iv;
      logic [4:0]  e_itid;
      logic        e_cv;
      logic [4:0]  e_ctid;
      logic [63:0] e_cres;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic scoreboard_entry mk_entry(input logic [4:0] rd, input logic exv);
      scoreboard_entry e;
      e          = '0;
      e.pc       = 64'h8000_0000 + 64'(rd);
      e.trans_id = 5'h1F;
      e.rd       = rd;
      e.valid    = 1'b1;
      e.ex.valid = exv;
      e.ex.cause = exv ? ILLEGAL_INSTR : 64'd0;
      return e;
   endfunction

   function automatic vec_t mk(input string name, input logic dv, input logic [4:0] rd,
                               input logic ia, input logic wv, input logic [4:0] tid,
                               input logic [63:0] wd, input logic ca, input logic e_full,
                               input logic e_iv, input logic [4:0] e_itid, input logic e_cv,
                               input logic [4:0] e_ctid, input logic [63:0] e_cres);
      vec_t v;
      v.name = name; v.dv = dv; v.rd = rd; v.ia = ia; v.wv = wv; v.tid = tid; v.wd = wd;
      v.ca = ca; v.e_full = e_full; v.e_iv = e_iv; v.e_itid = e_itid; v.e_cv = e_cv;
      v.e_ctid = e_ctid; v.e_cres = e_cres;
      return v;
   endfunction

   task automatic idle();
      flush = 1'b0; dec_valid = 1'b0; dec_instr = '0; issue_ack = 1'b0;
      wb_valid = 1'b0; trans_id = '0; wdata = '0; ex_in = '0; commit_ack = 1'b0;
   endtask

   task automatic cycle(input logic dv, input scoreboard_entry e, input logic ia, input logic wv,
                        input logic [4:0] tid, input logic [63:0] wd, input exception exi,
                        input logic ca, input logic fl);
      dec_valid = dv; dec_instr = e; issue_ack = ia; wb_valid = wv; trans_id = tid;
      wdata = wd; ex_in = exi; commit_ack = ca; flush = fl;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic insert(input logic [4:0] rd, input logic exv);
      cycle(1'b1, mk_entry(rd, exv), 1'b0, 1'b0, 5'd0, 64'd0, '0, 1'b0, 1'b0);
   endtask

   task automatic issue();
      cycle(1'b0, '0, 1'b1, 1'b0, 5'd0, 64'd0, '0, 1'b0, 1'b0);
   endtask

   task automatic wb(input logic [4:0] tid, input logic [63:0] wd);
      cycle(1'b0, '0, 1'b0, 1'b1, tid, wd, '0, 1'b0, 1'b0);
   endtask

   task automatic commit();
      cycle(1'b0, '0, 1'b0, 1'b0, 5'd0, 64'd0, '0, 1'b1, 1'b0);
   endtask

   task automatic apply(input vec_t v);
      cycle(v.dv, mk_entry(v.rd, 1'b0), v.ia, v.wv, v.tid, v.wd, '0, v.ca, 1'b0);
      check({v.name, " full"}, full, v.e_full);
      check({v.name, " ack"}, dec_ack, !v.e_full);
      check({v.name, " issue_valid"}, issue_valid, v.e_iv);
      if (v.e_iv) check({v.name, " issue_tid"}, issue_instr.trans_id, v.e_itid);
      check({v.name, " commit_valid"}, commit_valid, v.e_cv);
      if (v.e_cv) begin
         check({v.name, " commit_tid"}, commit_instr.trans_id, v.e_ctid);
         check({v.name, " commit_result"}, commit_instr.result, v.e_cres);
      end
   endtask

   initial begin
      rst = 1'b0;
      rs1 = 5'd5;
      rs2 = 5'd5;
      do_reset();
      check("reset full", full, 1'b0);
      check("reset ack", dec_ack, 1'b1);
      check("reset issue_valid", issue_valid, 1'b0);
      check("reset commit_valid", commit_valid, 1'b0);
      check("reset rs1_valid", rs1_valid, 1'b0);
      check("reset rs2_valid", rs2_valid, 1'b0);

      // Fill and drain, then out-of-order writeback; pointers are back at slot 0 after the drain.
      for (int i = 0; i < 8; i++)
         vq.push_back(mk($sformatf("fill%0d", i), 1, 5'(i + 1), 0, 0, 0, 0, 0, i == 7, 1, 0, 0, 0, 0));
      vq.push_back(mk("ninth", 1, 5'd9, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) begin
         vq.push_back(mk($sformatf("iss%0d", k), 0, 0, 1, 0, 0, 0, 0, k == 0, k < 7, 5'(k + 1), 0, 0, 0));
         vq.push_back(mk($sformatf("wb%0d", k), 0, 0, 0, 1, 5'(k), 64'(256 + k), 0, k == 0, k < 7,
                         5'(k + 1), 1, 5'(k), 64'(256 + k)));
         vq.push_back(mk($sformatf("cmt%0d", k), 0, 0, 0, 0, 0, 0, 1, 0, k < 7, 5'(k + 1), 0, 0, 0));
      end
      for (int i = 0; i < 3; i++)
         vq.push_back(mk($sformatf("ooo_ins%0d", i), 1, 5'(i + 10), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vq.push_back(mk("ooo_iss0", 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vq.push_back(mk("ooo_iss1", 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
      vq.push_back(mk("ooo_iss2", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk("ooo_wb2", 0, 0, 0, 1, 2, 64'h22, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk("ooo_wb1", 0, 0, 0, 1, 1, 64'h11, 0, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk("ooo_wb0", 0, 0, 0, 1, 0, 64'hAA, 0, 0, 0, 0, 1, 0, 64'hAA));
      vq.push_back(mk("ooo_cmt0", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 64'h11));
      vq.push_back(mk("ooo_cmt1", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 64'h22));
      vq.push_back(mk("ooo_cmt2", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      foreach (vq[i]) apply(vq[i]);

      // Wrap-around: 13 single-entry round trips from a fresh reset.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         check($sformatf("wrap%0d idle issue_valid", i), issue_valid, 1'b0);
         insert(5'(i + 1), 1'b0);
         check($sformatf("wrap%0d issue_valid", i), issue_valid, 1'b1);
         check($sformatf("wrap%0d issue_tid", i), issue_instr.trans_id, 5'(i % 8));
         issue();
         check($sformatf("wrap%0d issued", i), issue_valid, 1'b0);
         wb(5'(i % 8), 64'(i));
         check($sformatf("wrap%0d commit_valid", i), commit_valid, 1'b1);
         check($sformatf("wrap%0d commit_tid", i), commit_instr.trans_id, 5'(i % 8));
         commit();
         check($sformatf("wrap%0d retired", i), commit_valid, 1'b0);
      end

      // Flush with four occupied (two issued) plus a simultaneous insert, issue and writeback.
      do_reset();
      for (int i = 0; i < 4; i++) insert(5'(i + 1), 1'b0);
      issue();
      issue();
      check("flush pre issue_tid", issue_instr.trans_id, 5'd2);
      cycle(1'b1, mk_entry(5'd7, 1'b0), 1'b1, 1'b1, 5'd0, 64'h55, '0, 1'b0, 1'b1);
      check("flush full", full, 1'b0);
      check("flush ack", dec_ack, 1'b1);
      check("flush issue_valid", issue_valid, 1'b0);
      check("flush commit_valid", commit_valid, 1'b0);
      insert(5'd1, 1'b0);
      check("flush next tid", issue_instr.trans_id, 5'd0);
      issue();
      check("flush stale wb", commit_valid, 1'b0);
      for (int i = 1; i < 7; i++) insert(5'(i + 1), 1'b0);
      check("flush count 7 not full", full, 1'b0);
      insert(5'd8, 1'b0);
      check("flush count 8 full", full, 1'b1);

      // Decode exception completes without any writeback once issued.
      do_reset();
      insert(5'd3, 1'b1);
      issue();
      check("exc commit_valid", commit_valid, 1'b1);
      check("exc cause", commit_instr.ex.cause, ILLEGAL_INSTR);
      check("exc ex_valid", commit_instr.ex.valid, 1'b1);
      check("exc tid", commit_instr.trans_id, 5'd0);
      commit();
      check("exc retired", commit_valid, 1'b0);

      // Forwarding: two writers of rd=5, the younger one decides.
      do_reset();
      insert(5'd5, 1'b0);
      insert(5'd5, 1'b0);
      issue();
      issue();
      check("fwd none rs1_valid", rs1_valid, 1'b0);
      wb(5'd0, 64'h11);
      check("fwd older only rs1_valid", rs1_valid, 1'b0);
      wb(5'd1, 64'h22);
      check("fwd rs1_valid", rs1_valid, FWD);
      check("fwd rs1_data", rs1_data, FWD ? 64'h22 : 64'h0);
      check("fwd rs2_valid", rs2_valid, FWD);
      check("fwd rs2_data", rs2_data, FWD ? 64'h22 : 64'h0);
      rs1 = 5'd0;
      #1;
      check("fwd x0 rs1_valid", rs1_valid, 1'b0);
      rs2 = 5'd9;
      #1;
      check("fwd nomatch rs2_valid", rs2_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
